// File: rtl/addr_region_router.sv
// Registered multi-region address decoder with programmable windows.
// Lowest-index region wins on overlap; misses are counted.
module addr_region_router #(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_REGIONS    = 4,
  parameter int MISS_CNT_WIDTH = 16,
  localparam int IDX_WIDTH     = $clog2(NUM_REGIONS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [IDX_WIDTH-1:0]      cfg_idx,
  input  logic [ADDR_WIDTH-1:0]     cfg_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_bound,
  input  logic                      cfg_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [NUM_REGIONS-1:0]    out_sel,
  output logic [IDX_WIDTH-1:0]      out_idx,
  output logic                      out_miss,
  output logic [MISS_CNT_WIDTH-1:0] miss_count,
  input  logic                      miss_clr
);

  logic [ADDR_WIDTH-1:0]  base_q  [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0]  bound_q [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] en_q;

  logic [NUM_REGIONS-1:0] match;
  logic [NUM_REGIONS-1:0] dec_sel;
  logic [IDX_WIDTH-1:0]   dec_idx;
  logic                   dec_miss;
  logic                   accept;

  assign req_ready = !out_valid || out_ready;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]  <= '0;
        bound_q[i] <= '0;
      end
      en_q <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (cfg_idx == IDX_WIDTH'(i)) begin
          base_q[i]  <= cfg_base;
          bound_q[i] <= cfg_bound;
          en_q[i]    <= cfg_en;
        end
      end
    end
  end

  // base >= bound makes the window empty without a special case
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      match[i] = en_q[i]
              && (req_addr >= base_q[i])
              && (req_addr < bound_q[i]);
    end
  end

  // descending scan so the lowest matching index is written last
  always_comb begin
    dec_sel = '0;
    dec_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        dec_sel = NUM_REGIONS'(1) << i;
        dec_idx = IDX_WIDTH'(i);
      end
    end
  end

  assign dec_miss = ~|match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_sel   <= '0;
      out_idx   <= '0;
      out_miss  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_addr  <= req_addr;
      out_sel   <= dec_sel;
      out_idx   <= dec_idx;
      out_miss  <= dec_miss;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= '0;
    end else if (miss_clr) begin
      miss_count <= '0;
    end else if (accept && dec_miss && (miss_count != '1)) begin
      miss_count <= miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_addr_region_router.sv
// Scoreboard bench for addr_region_router.
// Expected decodes come from a bench-side region model.
module tb_addr_region_router;

  localparam int AW = 32;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_bound = '0;
  logic          cfg_en = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [NR-1:0] out_sel;
  logic [IW-1:0] out_idx;
  logic          out_miss;
  logic [CW-1:0] miss_count;
  logic          miss_clr = 1'b0;

  always #5 clk = ~clk;

  addr_region_router #(
    .ADDR_WIDTH(AW),
    .NUM_REGIONS(NR),
    .MISS_CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_base(cfg_base),
    .cfg_bound(cfg_bound),
    .cfg_en(cfg_en),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_sel(out_sel),
    .out_idx(out_idx),
    .out_miss(out_miss),
    .miss_count(miss_count),
    .miss_clr(miss_clr)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [NR-1:0] sel;
    logic [IW-1:0] idx;
    logic          miss;
  } exp_t;

  exp_t          sbq[$];
  exp_t          e_push;
  exp_t          e_pop;
  logic [AW-1:0] m_base  [NR];
  logic [AW-1:0] m_bound [NR];
  logic          m_en    [NR];
  logic [CW-1:0] exp_cnt;
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic exp_t model(input logic [AW-1:0] a);
    exp_t e;
    e.addr = a;
    e.sel  = '0;
    e.idx  = '0;
    e.miss = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (e.miss && m_en[i] && a >= m_base[i] && a < m_bound[i]) begin
        e.miss   = 1'b0;
        e.sel[i] = 1'b1;
        e.idx    = IW'(i);
      end
    end
    return e;
  endfunction

  // inputs change just after posedge, so negedge sees the values the next edge uses
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      exp_cnt = '0;
      for (int i = 0; i < NR; i++) begin
        m_base[i]  = '0;
        m_bound[i] = '0;
        m_en[i]    = 1'b0;
      end
    end else begin
      n_checks++;
      if (miss_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL sb_miss_count got=%0d exp=%0d t=%0t", miss_count, exp_cnt, $time);
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_output addr=%h t=%0t", out_addr, $time);
        end else begin
          e_pop = sbq.pop_front();
          if ({out_addr, out_sel, out_idx, out_miss} !==
              {e_pop.addr, e_pop.sel, e_pop.idx, e_pop.miss}) begin
            n_fail++;
            $display("FAIL sb_result got=%h/%b/%0d/%b exp=%h/%b/%0d/%b",
                     out_addr, out_sel, out_idx, out_miss,
                     e_pop.addr, e_pop.sel, e_pop.idx, e_pop.miss);
          end
        end
      end
      if (req_valid && req_ready) begin
        e_push = model(req_addr);
        sbq.push_back(e_push);
        if (e_push.miss && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      end
      if (miss_clr) exp_cnt = '0;
      if (cfg_we) begin
        m_base[cfg_idx]  = cfg_base;
        m_bound[cfg_idx] = cfg_bound;
        m_en[cfg_idx]    = cfg_en;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a);
    int k;
    req_valid = 1'b1;
    req_addr  = a;
    k = 0;
    while (!req_ready && k < 20) begin
      cyc();
      k++;
    end
    n_checks++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL send_timeout addr=%h req_ready=%b exp=1", a, req_ready);
    end
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic cfg(input logic [IW-1:0] i, input logic [AW-1:0] b,
                     input logic [AW-1:0] bd, input logic en);
    cfg_we    = 1'b1;
    cfg_idx   = i;
    cfg_base  = b;
    cfg_bound = bd;
    cfg_en    = en;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_addr, out_sel, out_idx, out_miss, miss_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b a=%h s=%b i=%0d m=%b c=%0d exp all 0",
               out_valid, out_addr, out_sel, out_idx, out_miss, miss_count);
    end
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", req_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    cfg(2'd0, 32'h0000, 32'h1000, 1'b1);
    cfg(2'd1, 32'h1000, 32'h2000, 1'b1);
    send(32'h0FFF);
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 4'b0001 || out_idx !== 2'd0 || out_miss !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_r0 got v=%b s=%b i=%0d m=%b exp 1/0001/0/0", out_valid, out_sel, out_idx, out_miss);
    end
    send(32'h1000);
    n_checks++;
    if (out_sel !== 4'b0010 || out_idx !== 2'd1 || out_miss !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_r1 got s=%b i=%0d m=%b exp 0010/1/0", out_sel, out_idx, out_miss);
    end
    send(32'h2000);
    n_checks++;
    if (out_miss !== 1'b1 || out_sel !== 4'b0000 || out_idx !== 2'd0 || miss_count !== 2'd1) begin
      n_fail++;
      $display("FAIL basic_miss got m=%b s=%b i=%0d c=%0d exp 1/0000/0/1", out_miss, out_sel, out_idx, miss_count);
    end
  endtask

  task automatic test_overlap();
    cfg(2'd2, 32'h0800, 32'h1800, 1'b1);
    cfg(2'd3, 32'h3000, 32'h3000, 1'b1);
    send(32'h1200);
    n_checks++;
    if (out_idx !== 2'd1 || out_sel !== 4'b0010) begin
      n_fail++;
      $display("FAIL overlap_r1 got s=%b i=%0d exp 0010/1", out_sel, out_idx);
    end
    send(32'h0900);
    n_checks++;
    if (out_idx !== 2'd0 || out_sel !== 4'b0001) begin
      n_fail++;
      $display("FAIL overlap_r0 got s=%b i=%0d exp 0001/0", out_sel, out_idx);
    end
    send(32'h3000);
    n_checks++;
    if (out_miss !== 1'b1 || out_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL empty_region got m=%b s=%b exp 1/0000", out_miss, out_sel);
    end
  endtask

  task automatic test_backpressure();
    cyc();
    out_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0010;
    cyc();
    req_addr = 32'h1500;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (req_ready !== 1'b0 || out_valid !== 1'b1 ||
          {out_addr, out_sel, out_idx, out_miss} !== {32'h0010, 4'b0001, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d got rdy=%b v=%b a=%h s=%b exp rdy=0 v=1 a=00000010 s=0001",
                 k, req_ready, out_valid, out_addr, out_sel);
      end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready got=%b exp=1", req_ready);
    end
    cyc();
    n_checks++;
    if (out_addr !== 32'h1500 || out_idx !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second got a=%h i=%0d v=%b exp 1500/1/1", out_addr, out_idx, out_valid);
    end
    req_addr = 32'h2800;
    cyc();
    n_checks++;
    if (out_addr !== 32'h2800 || out_miss !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_third got a=%h m=%b exp 2800/1", out_addr, out_miss);
    end
    req_valid = 1'b0;
    cyc();
    n_checks++;
    if (out_valid !== 1'b0 || miss_count !== 2'd3) begin
      n_fail++;
      $display("FAIL bp_drain got v=%b c=%0d exp 0/3", out_valid, miss_count);
    end
  endtask

  task automatic test_same_cycle_cfg();
    cyc();
    out_ready = 1'b1;
    cfg_we    = 1'b1;
    cfg_idx   = 2'd0;
    cfg_base  = 32'h0000;
    cfg_bound = 32'h1000;
    cfg_en    = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0010;
    cyc();
    cfg_we    = 1'b0;
    req_valid = 1'b0;
    n_checks++;
    if (out_idx !== 2'd0 || out_sel !== 4'b0001 || out_miss !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_old_decode got s=%b i=%0d m=%b exp 0001/0/0", out_sel, out_idx, out_miss);
    end
    send(32'h0010);
    n_checks++;
    if (out_miss !== 1'b1 || miss_count !== 2'd3) begin
      n_fail++;
      $display("FAIL cfg_new_decode got m=%b c=%0d exp 1/3", out_miss, miss_count);
    end
    cyc();
    out_ready = 1'b0;
    send(32'h1000);
    cfg(2'd1, 32'h1000, 32'h2000, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 4'b0010 || out_idx !== 2'd1 || out_miss !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_held_output got v=%b s=%b i=%0d m=%b exp 1/0010/1/0", out_valid, out_sel, out_idx, out_miss);
    end
    out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_counter();
    miss_clr = 1'b1;
    cyc();
    miss_clr = 1'b0;
    n_checks++;
    if (miss_count !== 2'd0) begin
      n_fail++;
      $display("FAIL cnt_clear got=%0d exp=0", miss_count);
    end
    for (int k = 1; k <= 5; k++) begin
      send(32'h5000);
      n_checks++;
      if (miss_count !== CW'((k > 3) ? 3 : k)) begin
        n_fail++;
        $display("FAIL cnt_step%0d got=%0d exp=%0d", k, miss_count, (k > 3) ? 3 : k);
      end
    end
    miss_clr  = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h5000;
    cyc();
    miss_clr  = 1'b0;
    req_valid = 1'b0;
    n_checks++;
    if (miss_count !== 2'd0 || out_miss !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt_clr_priority got c=%0d m=%b exp 0/1", miss_count, out_miss);
    end
  endtask

  task automatic test_reset_midstream();
    cyc();
    send(32'h5000);
    cfg(2'd0, 32'h0000, 32'h1000, 1'b1);
    out_ready = 1'b0;
    send(32'h0100);
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_miss !== 1'b0 || miss_count !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_pre got v=%b i=%0d m=%b c=%0d exp 1/0/0/1", out_valid, out_idx, out_miss, miss_count);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || miss_count !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset got v=%b c=%0d exp 0/0", out_valid, miss_count);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release got rdy=%b v=%b exp 1/0", req_ready, out_valid);
    end
    out_ready = 1'b1;
    send(32'h0100);
    n_checks++;
    if (out_miss !== 1'b1 || out_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_regions_cleared got m=%b s=%b exp 1/0000", out_miss, out_sel);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_backpressure();
    test_same_cycle_cfg();
    test_counter();
    test_reset_midstream();
    out_ready = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d exp=0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_region_router.md
Name: addr_region_router

Overview:
- Registered multi-region address decoder with runtime-programmable windows.
- Each of NUM_REGIONS regions holds a base, a bound and an enable bit, written over a config port.
- Incoming requests are decoded against all regions into a one-hot select, a region index and a miss flag, then held in a valid/ready output register.
- Sits between a bus master and the peripheral/memory select fabric; also counts decode misses.

Parameters:
- ADDR_WIDTH, 32, address width in bits (≥2).
- NUM_REGIONS, 4, number of decode regions (≥2).
- IDX_WIDTH, $clog2(NUM_REGIONS), region index width (derived, not overridden).
- MISS_CNT_WIDTH, 16, miss counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_idx  in  IDX_WIDTH  region being written; values ≥ NUM_REGIONS are ignored.
- cfg_base  in  ADDR_WIDTH  region base, inclusive.
- cfg_bound  in  ADDR_WIDTH  region bound, exclusive.
- cfg_en  in  1  region enable.
- req_valid  in  1  request present.
- req_ready  out  1  router can accept a request.
- req_addr  in  ADDR_WIDTH  request address.
- out_valid  out  1  decoded result present.
- out_ready  in  1  downstream accepts the result.
- out_addr  out  ADDR_WIDTH  registered request address.
- out_sel  out  NUM_REGIONS  one-hot region select; all zero on miss.
- out_idx  out  IDX_WIDTH  index of the selected region; 0 on miss.
- out_miss  out  1  no enabled region matched.
- miss_count  out  MISS_CNT_WIDTH  saturating count of accepted misses.
- miss_clr  in  1  synchronous clear of miss_count.

Behaviour:
- Reset: rst_n low asynchronously clears all state.
  - Every region: base=0, bound=0, en=0.
  - out_valid=0, out_addr=0, out_sel=0, out_idx=0, out_miss=0, miss_count=0.
  - req_ready is 1 one cycle after reset deasserts, with out_valid=0.
  - An in-flight result is discarded by reset; nothing is replayed.
- Region match: region i matches when en_i=1 and base_i ≤ req_addr < bound_i.
  - Comparisons are unsigned, full ADDR_WIDTH.
  - A region with base ≥ bound is empty and never matches.
- Priority: overlapping regions resolve to the lowest index. out_sel always has at most one bit set.
- Handshake:
  - req_ready = !out_valid || out_ready, combinational.
  - A request is accepted when req_valid && req_ready.
  - On accept, the decode result is registered and out_valid=1 on the next edge. Latency is 1 cycle; throughput is 1 request per cycle when out_ready is held high.
  - While out_valid && !out_ready, all out_* signals hold stable and req_ready=0.
  - If out_valid && out_ready and no request is accepted in that cycle, out_valid goes to 0 on the next edge.
- Config timing:
  - A write takes effect at the edge where cfg_we=1; the region registers update on that edge.
  - A request accepted in the same cycle decodes against the pre-write values.
  - A held output is never re-decoded after a config change.
- Miss counter:
  - Increments by 1 on each accepted request that misses.
  - Saturates at all-ones; no wrap.
  - miss_clr has priority over increment: same-cycle clear and miss gives 0.
- out_miss=1 implies out_sel=0 and out_idx=0.

Test Plan:
- Reset and hold: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, miss_count=0, all regions disabled; after release, req_addr=0x100 -> out_miss=1.
- Basic decode (ADDR_WIDTH=32, NUM_REGIONS=4): program r0=[0x0000,0x1000), r1=[0x1000,0x2000), both enabled. req_addr 0x0FFF, 0x1000, 0x2000 ->
  - out_sel=0001, out_idx=0
  - out_sel=0010, out_idx=1
  - out_miss=1, miss_count=1
- Overlap and empty region: r2=[0x0800,0x1800), r1 as above, r3 base=bound=0x3000 enabled. Addr 0x1200 -> out_idx=1; 0x3000 -> miss.
- Backpressure: 3 back-to-back requests with out_ready=0 for 4 cycles -> req_ready=0 after first accept, outputs stable, then results delivered in order, one per cycle.
- Same-cycle config write and request: disable r0 while requesting 0x0010 -> result out_idx=0 (old config); next request 0x0010 -> miss.
- Counter: MISS_CNT_WIDTH=2, 5 misses -> miss_count=3; miss_clr together with a miss -> 0.
